// File: rtl/data_port_arbiter_pkg.sv
// Shared types for the data-cache port arbiter: request payload and requester IDs.
package data_port_arbiter_pkg;

    typedef struct packed {
        logic        wr;
        logic [2:0]  size;
        logic [3:0]  wstrb;
        logic [3:0]  offset;
        logic [7:0]  index;
        logic [19:0] tag;
        logic        iscache;
        logic [31:0] wdata;
    } dreq_t;

    typedef enum logic [0:0] {
        REQ_PIPE = 1'b0,
        REQ_SBUF = 1'b1
    } req_id_t;

endpackage

// File: rtl/data_port_arbiter_if.sv
// One request/response port of the data cache; used for both requesters and the downstream side.
interface data_port_arbiter_if;
    import data_port_arbiter_pkg::*;

    logic        req;
    dreq_t       req_t;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (output req, req_t, input addr_ok, data_ok, rdata);
    modport slave  (input req, req_t, output addr_ok, data_ok, rdata);

endinterface

// File: rtl/data_port_arbiter_id_fifo.sv
// Small synchronous FIFO; head entry is readable combinationally so responses route in the same cycle.
module id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_din,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_dout,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd_ptr];

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/data_port_arbiter.sv
// Arbitrates the data-cache port between the pipe (s0) and store-buffer drain (s1), with
// grant locking, sbuf starvation protection and in-order response routing.
module data_port_arbiter
    import data_port_arbiter_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int STARVE_LIMIT    = 8
) (
    input  logic                 clk,
    input  logic                 resetn,
    data_port_arbiter_if.slave   s0,
    data_port_arbiter_if.slave   s1,
    data_port_arbiter_if.master  m,
    output logic                 proto_err
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic          r_locked;
    req_id_t       r_lock_id;
    logic [SW-1:0] r_starve_cnt;
    logic          r_proto_err;

    logic          w_locked_next;
    req_id_t       w_lock_id_next;
    logic [SW-1:0] w_starve_cnt_next;

    req_id_t       w_gnt;
    logic          w_gnt_valid;
    logic          w_gnt_req;
    dreq_t         w_gnt_payload;
    logic          w_m_req;
    logic          w_accept;
    logic          w_pop;
    logic [0:0]    w_head;
    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [CW-1:0] w_fifo_count;

    // Grant: lock owner first, then pipe unless sbuf has waited long enough.
    always_comb begin
        w_gnt       = REQ_PIPE;
        w_gnt_valid = 1'b0;
        if (r_locked) begin
            w_gnt       = r_lock_id;
            w_gnt_valid = 1'b1;
        end else if (s0.req && !(s1.req && r_starve_cnt == SW'(STARVE_LIMIT))) begin
            w_gnt       = REQ_PIPE;
            w_gnt_valid = 1'b1;
        end else if (s1.req) begin
            w_gnt       = REQ_SBUF;
            w_gnt_valid = 1'b1;
        end
    end

    assign w_gnt_req     = (w_gnt == REQ_SBUF) ? s1.req : s0.req;
    assign w_gnt_payload = (w_gnt == REQ_SBUF) ? s1.req_t : s0.req_t;
    assign w_m_req       = w_gnt_valid && w_gnt_req && !w_fifo_full;
    assign w_accept      = w_m_req && m.addr_ok;

    always_comb begin
        w_locked_next  = r_locked;
        w_lock_id_next = r_lock_id;
        if (w_accept) begin
            w_locked_next = 1'b0;
        end else if (w_m_req) begin
            w_locked_next  = 1'b1;
            w_lock_id_next = w_gnt;
        end else if (r_locked && !w_gnt_req) begin
            // Owner withdrew (e.g. pipeline flush); release so the other side can go.
            w_locked_next = 1'b0;
        end

        w_starve_cnt_next = r_starve_cnt;
        if (!s1.req || (w_accept && w_gnt == REQ_SBUF)) begin
            w_starve_cnt_next = '0;
        end else if (r_starve_cnt != SW'(STARVE_LIMIT)) begin
            w_starve_cnt_next = r_starve_cnt + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_locked     <= 1'b0;
            r_lock_id    <= REQ_PIPE;
            r_starve_cnt <= '0;
            r_proto_err  <= 1'b0;
        end else begin
            r_locked     <= w_locked_next;
            r_lock_id    <= w_lock_id_next;
            r_starve_cnt <= w_starve_cnt_next;
            if (m.data_ok && w_fifo_count == '0) r_proto_err <= 1'b1;
        end
    end

    assign w_pop = m.data_ok && !w_fifo_empty;

    id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .i_push  (w_accept),
        .i_din   (w_gnt),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    // Everything combinational is forced quiet while reset is asserted.
    assign m.req      = resetn && w_m_req;
    assign m.req_t    = resetn ? w_gnt_payload : '0;
    assign s0.addr_ok = resetn && w_accept && (w_gnt == REQ_PIPE);
    assign s1.addr_ok = resetn && w_accept && (w_gnt == REQ_SBUF);
    assign s0.data_ok = resetn && w_pop && (w_head == 1'b0);
    assign s1.data_ok = resetn && w_pop && (w_head == 1'b1);
    assign s0.rdata   = resetn ? m.rdata : '0;
    assign s1.rdata   = resetn ? m.rdata : '0;
    assign proto_err  = r_proto_err;

endmodule

// File: tb/tb_data_port_arbiter.sv
// Directed bench for data_port_arbiter: stimulus queues expected accepts/responses, a monitor checks them.
module tb_data_port_arbiter;
    import data_port_arbiter_pkg::*;

    logic clk = 1'b0;
    logic resetn;
    logic proto_err;

    always #5 clk = ~clk;

    data_port_arbiter_if s0_if ();
    data_port_arbiter_if s1_if ();
    data_port_arbiter_if m_if ();

    data_port_arbiter #(
        .MAX_OUTSTANDING (4),
        .STARVE_LIMIT    (8)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .s0        (s0_if),
        .s1        (s1_if),
        .m         (m_if),
        .proto_err (proto_err)
    );

    typedef struct {
        logic [1:0]  port_oh;
        logic [31:0] rdata;
    } rsp_t;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [1:0] exp_acc_q [$];
    rsp_t       exp_rsp_q [$];
    dreq_t      p0;
    dreq_t      p1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic cyc(input logic r0, input logic r1, input logic aok,
                       input logic dok, input logic [31:0] rd);
        @(posedge clk);
        #1;
        s0_if.req     = r0;
        s1_if.req     = r1;
        m_if.addr_ok  = aok;
        m_if.data_ok  = dok;
        m_if.rdata    = rd;
        #3;
    endtask

    task automatic push_acc(input int id);
        exp_acc_q.push_back(id != 0 ? 2'b10 : 2'b01);
    endtask

    task automatic push_rsp(input int id, input logic [31:0] rd);
        rsp_t r;
        r.port_oh = (id != 0) ? 2'b10 : 2'b01;
        r.rdata   = rd;
        exp_rsp_q.push_back(r);
    endtask

    // Monitor: every accept / response the DUT presents must match the head of its queue.
    always @(negedge clk) begin
        logic [1:0] e;
        rsp_t       r;
        if (resetn === 1'b1) begin
            if (s0_if.addr_ok || s1_if.addr_ok) begin
                if (exp_acc_q.size() == 0) begin
                    chk("unexpected_accept", {s1_if.addr_ok, s0_if.addr_ok}, 2'b00);
                end else begin
                    e = exp_acc_q.pop_front();
                    chk("accept_port", {s1_if.addr_ok, s0_if.addr_ok}, e);
                    chk("accept_tag", m_if.req_t.tag, (e == 2'b10) ? p1.tag : p0.tag);
                    $display("t=%0t accept port_oh=%b tag=%h", $time,
                             {s1_if.addr_ok, s0_if.addr_ok}, m_if.req_t.tag);
                end
            end
            if (s0_if.data_ok || s1_if.data_ok) begin
                if (exp_rsp_q.size() == 0) begin
                    chk("unexpected_data_ok", {s1_if.data_ok, s0_if.data_ok}, 2'b00);
                end else begin
                    r = exp_rsp_q.pop_front();
                    chk("data_ok_port", {s1_if.data_ok, s0_if.data_ok}, r.port_oh);
                    chk("rdata", s1_if.data_ok ? s1_if.rdata : s0_if.rdata, r.rdata);
                    $display("t=%0t data_ok port_oh=%b rdata=%h", $time,
                             {s1_if.data_ok, s0_if.data_ok}, m_if.rdata);
                end
            end
        end
    end

    int acc_ids [10] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0};

    initial begin
        p0 = '{wr: 1'b0, size: 3'd2, wstrb: 4'hF, offset: 4'h4, index: 8'h12,
               tag: 20'hAAAAA, iscache: 1'b1, wdata: 32'h0};
        p1 = '{wr: 1'b1, size: 3'd2, wstrb: 4'h3, offset: 4'h8, index: 8'h34,
               tag: 20'h55555, iscache: 1'b1, wdata: 32'hDEADBEEF};
        s0_if.req_t  = p0;
        s1_if.req_t  = p1;

        // Reset: outputs stay low even with live inputs.
        resetn       = 1'b0;
        s0_if.req    = 1'b1;
        s1_if.req    = 1'b0;
        m_if.addr_ok = 1'b1;
        m_if.data_ok = 1'b1;
        m_if.rdata   = 32'hFFFF_FFFF;
        #3;
        chk("reset_m_req", m_if.req, 1'b0);
        chk("reset_s0_addr_ok", s0_if.addr_ok, 1'b0);
        chk("reset_s0_data_ok", s0_if.data_ok, 1'b0);
        chk("reset_proto_err", proto_err, 1'b0);
        s0_if.req    = 1'b0;
        m_if.addr_ok = 1'b0;
        m_if.data_ok = 1'b0;
        m_if.rdata   = 32'h0;
        @(negedge clk);
        resetn = 1'b1;

        // Starvation: eight pipe accepts, sbuf on the ninth, then pipe wins again.
        for (int c = 0; c < 10; c++) begin
            cyc(1'b1, 1'b1, 1'b1, c > 0, 32'h50 + c);
            push_acc(acc_ids[c]);
            if (c > 0) push_rsp(acc_ids[c-1], 32'h50 + c);
        end
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h5A);
        push_rsp(acc_ids[9], 32'h5A);

        // Lock on pipe while addr_ok is low.
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("lock_m_req", m_if.req, 1'b1);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("lock_hold_pipe", m_if.req_t.tag, p0.tag);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("lock_hold_pipe2", m_if.req_t.tag, p0.tag);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        push_acc(0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        push_acc(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h61);
        push_rsp(0, 32'h61);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h62);
        push_rsp(1, 32'h62);

        // Lock on sbuf holds even though pipe would otherwise win.
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("lock_hold_sbuf", m_if.req_t.tag, p1.tag);
        cyc(1'b1, 1'b1, 1'b1, 1'b0, 32'h0);
        push_acc(1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        push_acc(0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h63);
        push_rsp(1, 32'h63);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h64);
        push_rsp(0, 32'h64);

        // Pipe withdraws while locked: lock drops, sbuf goes next cycle.
        cyc(1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        chk("withdraw_pre_tag", m_if.req_t.tag, p0.tag);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("withdraw_m_req", m_if.req, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("withdraw_sbuf_req", m_if.req, 1'b1);
        push_acc(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h71);
        push_rsp(1, 32'h71);

        // Fill the ID FIFO, then check full blocking and ordered routing.
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); push_acc(0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); push_acc(1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0); push_acc(0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); push_acc(1);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("full_block", m_if.req, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 32'h11);
        chk("full_pop_block", m_if.req, 1'b0);
        push_rsp(0, 32'h11);
        cyc(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
        chk("after_pop_m_req", m_if.req, 1'b1);
        push_acc(0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        chk("refull_block", m_if.req, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h22); push_rsp(1, 32'h22);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h33); push_rsp(0, 32'h33);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h44); push_rsp(1, 32'h44);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h55); push_rsp(0, 32'h55);

        // Response with nothing outstanding: sticky error, no data_ok.
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("proto_err_idle", proto_err, 1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h99);
        chk("stray_no_data_ok", {s1_if.data_ok, s0_if.data_ok}, 2'b00);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("proto_err_set", proto_err, 1'b1);
        cyc(1'b0, 1'b1, 1'b1, 1'b0, 32'h0); push_acc(1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'hA1); push_rsp(1, 32'hA1);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        chk("proto_err_sticky", proto_err, 1'b1);

        // Asynchronous reset mid-cycle clears the error and silences outputs.
        @(posedge clk);
        #2;
        resetn       = 1'b0;
        s0_if.req    = 1'b1;
        m_if.addr_ok = 1'b1;
        m_if.data_ok = 1'b1;
        m_if.rdata   = 32'hFF;
        #1;
        chk("reset2_proto_err", proto_err, 1'b0);
        chk("reset2_m_req", m_if.req, 1'b0);
        chk("reset2_s0_addr_ok", s0_if.addr_ok, 1'b0);
        chk("reset2_s0_rdata", s0_if.rdata, 32'h0);
        s0_if.req    = 1'b0;
        m_if.addr_ok = 1'b0;
        m_if.data_ok = 1'b0;
        m_if.rdata   = 32'h0;
        @(negedge clk);
        resetn = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);

        chk("acc_queue_drained", exp_acc_q.size(), 0);
        chk("rsp_queue_drained", exp_rsp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/data_port_arbiter.md
# data_port_arbiter

Shares the single data-cache request port between two requesters: the pre-memory pipeline stage (port 0, "pipe") and the store buffer drain (port 1, "sbuf"). It sits between those two masters and the data cache / uncached bridge. It provides:
- grant selection with starvation protection for sbuf;
- grant locking while a presented request waits for addr_ok;
- an in-order ID FIFO that routes each data_ok/rdata back to the requester that issued it.

## Interface
Parameters:
- MAX_OUTSTANDING, 4: max accepted-but-unanswered transactions (power of two, ≥2).
- STARVE_LIMIT, 8: cycles sbuf may wait before it takes priority over pipe.

Ports (`s0_*` = pipe, `s1_*` = sbuf; each `sN_*` group has identical shape):
- clk  in  1  clock.
- resetn  in  1  asynchronous, active-low reset.
- sN_req  in  1  request valid.
- sN_req_t  in  dreq_t  request payload: wr, size[2:0], wstrb[3:0], offset[3:0], index[7:0], tag[19:0], iscache, wdata[31:0].
- sN_addr_ok  out  1  request accepted this cycle.
- sN_data_ok  out  1  response for this requester's oldest transaction.
- sN_rdata  out  32  read data; valid with sN_data_ok.
- m_req  out  1  downstream request.
- m_req_t  out  dreq_t  downstream payload, muxed from the granted requester.
- m_addr_ok  in  1  downstream accept.
- m_data_ok  in  1  downstream response.
- m_rdata  in  32  downstream read data.
- proto_err  out  1  sticky error: m_data_ok arrived with the ID FIFO empty.

## Operation
Grant is a combinational function of state and requests. It never depends on m_addr_ok.
- If `locked`: grant = `lock_id`.
- Else if s0_req and not (s1_req and starve_cnt == STARVE_LIMIT): grant = 0.
- Else if s1_req: grant = 1.
- Otherwise no grant; m_req = 0.

Downstream request and accept:
- m_req = sGrant_req && !fifo_full.
- m_req_t = payload of the granted requester.
- Accept = m_req && m_addr_ok.
- sGrant_addr_ok = accept; the non-granted sN_addr_ok = 0.

Lock register:
- Set (`locked` = 1, `lock_id` = grant) when m_req is high and m_addr_ok is low.
- Cleared on accept.
- Cleared if the owner drops its req, e.g. a pipeline flush withdraws the pipe request. Requesters may withdraw; the payload may change only after withdrawal.

Starvation counter `starve_cnt` (width clog2(STARVE_LIMIT+1)):
- +1 per cycle in which s1_req is high and s1 is not accepted.
- Saturates at STARVE_LIMIT.
- Cleared on s1 accept or when s1_req is low.

ID FIFO (depth MAX_OUTSTANDING, 1-bit entries):
- Push the grant ID on accept; pop on m_data_ok.
- `fifo_full` (count == MAX_OUTSTANDING) blocks m_req even if a pop occurs in the same cycle.
- Push and pop in the same cycle are legal when not full; count is unchanged.
- count wraps pointers modulo depth.

Response routing:
- sK_data_ok = m_data_ok && fifo_head == K.
- sN_rdata = m_rdata for both requesters.

Error handling:
- m_data_ok with the FIFO empty sets proto_err, which stays set until reset.
- In that case no sN_data_ok is asserted and no pop occurs.

Out of scope:
- Address hazards between pipe loads and buffered stores; sbuf forwards those itself.

## Timing
- Zero-cycle path from sN_req to m_req; m_addr_ok is passed straight to sN_addr_ok, combinationally.
- m_data_ok is passed straight to sN_data_ok in the same cycle.
- Arbitration decision, lock and starvation updates take effect the cycle after the triggering edge.
- Reset (async assert, synchronous-release assumed upstream):
  - locked = 0, lock_id = 0, starve_cnt = 0;
  - FIFO empty, pointers 0;
  - proto_err = 0;
  - all outputs 0 while resetn is low.
- Reset mid-transaction discards outstanding IDs. The downstream must be reset by the same resetn.
- Throughput: one accept per cycle when m_addr_ok is continuously high and the FIFO is not full.

## Structure
- Shared package (cpu.svh):
  - `dreq_t` struct;
  - `req_id_t` enum: REQ_PIPE = 0, REQ_SBUF = 1.
- One sub-module: `id_fifo`, a synchronous FIFO parameterised on DEPTH and WIDTH, providing full/empty and count outputs.
- Arbitration, lock and starvation logic live in data_port_arbiter.

## Test plan
- Both requesters high, m_addr_ok = 1 every cycle: pipe accepted for 8 cycles. On cycle 9, sbuf is accepted (starve_cnt = 8) and starve_cnt clears to 0.
- Pipe request with m_addr_ok low for 3 cycles; sbuf raises req on cycle 1: grant stays on pipe (locked) and pipe is accepted on cycle 4 when m_addr_ok = 1.
- Pipe withdraws req while locked with m_addr_ok low: lock clears and sbuf is granted the next cycle with no spurious s0_addr_ok.
- Issue 4 accepts (pipe, sbuf, pipe, sbuf) with no responses: m_req = 0 on the 5th request. Four m_data_ok pulses then give s0, s1, s0, s1 data_ok in order, with rdata = 0x11, 0x22, 0x33, 0x44 routed.
- With FIFO count = 4, m_data_ok and a new request in the same cycle: no accept that cycle; accept occurs next cycle with count = 4 again.
- m_data_ok with FIFO empty: proto_err = 1 and stays 1 through later traffic. It clears only when resetn = 0 and outputs return to 0.
